// File: rtl/lattice_scroll_feeder.sv
// rtl/lattice_scroll_feeder.sv - glyph FIFO and column scroller feeding the 8x8 lattice row scanner
module lattice_scroll_feeder #(
    parameter int STEP_DIV = 6250000,
    parameter int DEPTH    = 4,
    parameter int GAP      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic [63:0] glyph_in,
    input  logic        glyph_valid,
    output logic        glyph_ready,
    output logic [63:0] frame,
    output logic        frame_update,
    output logic        busy,
    output logic [3:0]  fifo_count
);

    localparam int CW = $clog2(STEP_DIV);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic [2:0]    GAP_LAST = 3'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, BLANK} state_t;

    state_t        state, state_next;
    logic [CW-1:0] step_cnt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [63:0]   mem [DEPTH];
    logic [63:0]   glyph;
    logic [2:0]    col;
    logic [2:0]    gap_cnt;
    logic          tick, push, pop, shift_en, gap_en;
    logic [63:0]   shifted, gapped;

    assign glyph_ready = rst && (fifo_count < 4'(DEPTH)) && !clear;
    assign push        = glyph_valid && glyph_ready;
    assign tick        = enable && (step_cnt == CNT_LAST);
    assign busy        = (state != IDLE);

    // Each row takes the next glyph column (or a blank) at bit 7 and drifts toward bit 0.
    always_comb begin
        shifted = '0;
        gapped  = '0;
        for (int r = 0; r < 8; r++) begin
            shifted[8*r +: 8] = {glyph[8*r + int'(col)], frame[8*r+1 +: 7]};
            gapped[8*r +: 8]  = {1'b0, frame[8*r+1 +: 7]};
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shift_en   = 1'b0;
        gap_en     = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != 4'd0 && enable) state_next = LOAD;
            end
            LOAD: begin
                pop        = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (col == 3'd7) begin
                        if (GAP > 0)                 state_next = BLANK;
                        else if (fifo_count != 4'd0) state_next = LOAD;
                        else                         state_next = IDLE;
                    end
                end
            end
            BLANK: begin
                if (tick) begin
                    gap_en = 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        if (fifo_count != 4'd0) state_next = LOAD;
                        else                    state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= glyph_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            step_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= 4'd0;
            glyph        <= '0;
            frame        <= '0;
            frame_update <= 1'b0;
            col          <= 3'd0;
            gap_cnt      <= 3'd0;
        end else if (clear) begin
            state        <= IDLE;
            step_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= 4'd0;
            frame        <= '0;
            frame_update <= |frame;
            col          <= 3'd0;
            gap_cnt      <= 3'd0;
        end else begin
            state        <= state_next;
            frame_update <= shift_en || gap_en;
            if (enable) step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                glyph   <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
                col     <= 3'd0;
                gap_cnt <= 3'd0;
            end
            if (push && !pop)      fifo_count <= fifo_count + 4'd1;
            else if (pop && !push) fifo_count <= fifo_count - 4'd1;
            if (shift_en) begin
                frame <= shifted;
                col   <= col + 3'd1;
            end
            if (gap_en) begin
                frame   <= gapped;
                gap_cnt <= gap_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_lattice_scroll_feeder.sv
// tb/tb_lattice_scroll_feeder.sv - directed bench for lattice_scroll_feeder (GAP=1 and GAP=0 instances)
module tb_lattice_scroll_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] glyph_in = '0;
    logic        glyph_valid = 1'b0;

    logic        ready0, upd0, busy0;
    logic [63:0] frame0;
    logic [3:0]  count0;
    logic        ready1, upd1, busy1;
    logic [63:0] frame1;
    logic [3:0]  count1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lattice_scroll_feeder #(.STEP_DIV(4), .DEPTH(4), .GAP(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .glyph_in(glyph_in), .glyph_valid(glyph_valid), .glyph_ready(ready0),
        .frame(frame0), .frame_update(upd0), .busy(busy0), .fifo_count(count0)
    );

    lattice_scroll_feeder #(.STEP_DIV(4), .DEPTH(4), .GAP(0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .glyph_in(glyph_in), .glyph_valid(glyph_valid), .glyph_ready(ready1),
        .frame(frame1), .frame_update(upd1), .busy(busy1), .fifo_count(count1)
    );

    task automatic wait_upd(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((which == 0) ? upd0 : upd1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic push_one(input logic [63:0] g);
        @(negedge clk);
        glyph_in    = g;
        glyph_valid = 1'b1;
        @(negedge clk);
        glyph_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (frame0 !== 64'd0 || upd0 !== 1'b0 || busy0 !== 1'b0 || count0 !== 4'd0 || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL reset: frame=%h upd=%b busy=%b count=%0d ready=%b, need 0/0/0/0/0",
                     frame0, upd0, busy0, count0, ready0);
        end
        vectors++;
        if (frame1 !== 64'd0 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_gap0: frame=%h ready=%b, need 0/0", frame1, ready1);
        end
        rst = 1'b1;
    endtask

    task automatic test_scroll_gap();
        bit ok;
        logic [7:0] row;
        enable = 1'b1;
        push_one(64'h0000_0000_0000_00FF);
        for (int k = 1; k <= 8; k++) begin
            wait_upd(0, ok);
            row = 8'hFF;
            row = row << (8 - k);
            vectors++;
            if (!ok || frame0 !== {56'd0, row}) begin
                errors++;
                $display("FAIL scroll_tick%0d: frame=%h timeout=%b, need %h", k, frame0, !ok, {56'd0, row});
            end
        end
        wait_upd(0, ok);
        vectors++;
        if (!ok || frame0 !== 64'h7F) begin
            errors++;
            $display("FAIL gap_tick: frame=%h timeout=%b, need 7f", frame0, !ok);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (busy0 !== 1'b0 || frame0 !== 64'h7F) begin
            errors++;
            $display("FAIL idle_hold: busy=%b frame=%h, need 0 and 7f", busy0, frame0);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        logic [63:0] g [5];
        g[0] = 64'h1111_2222_3333_4444;
        g[1] = 64'h5555_6666_7777_8888;
        g[2] = 64'h9999_AAAA_BBBB_CCCC;
        g[3] = 64'hDDDD_EEEE_FFFF_0000;
        g[4] = 64'h0123_4567_89AB_CDEF;
        enable = 1'b0;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            glyph_in    = g[i];
            glyph_valid = 1'b1;
            #1;
            vectors++;
            if (ready0 !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready%0d: ready=%b, need 1", i, ready0);
            end
        end
        @(negedge clk);
        glyph_in = g[4];
        #1;
        vectors++;
        if (ready0 !== 1'b0 || count0 !== 4'd4) begin
            errors++;
            $display("FAIL full: ready=%b count=%0d, need 0 and 4", ready0, count0);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (ready0 !== 1'b0 || count0 !== 4'd4 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: ready=%b count=%0d busy=%b, need 0 4 0", ready0, count0, busy0);
        end
        enable = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL load_cycle: ready=%b busy=%b, need 0 and 1", ready0, busy0);
        end
        @(negedge clk);
        vectors++;
        if (ready0 !== 1'b1 || count0 !== 4'd3) begin
            errors++;
            $display("FAIL after_pop: ready=%b count=%0d, need 1 and 3", ready0, count0);
        end
        @(negedge clk);
        glyph_valid = 1'b0;
        vectors++;
        if (count0 !== 4'd4) begin
            errors++;
            $display("FAIL fifth_accept: count=%0d, need 4", count0);
        end
        for (int k = 0; k < 8; k++) wait_upd(0, ok);
        vectors++;
        if (!ok || frame0 !== g[0]) begin
            errors++;
            $display("FAIL first_glyph: frame=%h timeout=%b, need %h", frame0, !ok, g[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_clear();
        enable = 1'b1;
        @(negedge clk);
        glyph_in    = 64'h0101_0101_0101_0101;
        glyph_valid = 1'b1;
        @(negedge clk);
        glyph_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        glyph_valid = 1'b0;
        for (int k = 0; k < 8; k++) wait_upd(1, ok);
        vectors++;
        if (!ok || frame1 !== 64'h0101_0101_0101_0101 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL glyph_a: frame=%h busy=%b timeout=%b, need 0101010101010101 and busy", frame1, busy1, !ok);
        end
        wait_upd(1, ok);
        vectors++;
        if (!ok || frame1 !== 64'h8080_8080_8080_8080) begin
            errors++;
            $display("FAIL no_gap: frame=%h timeout=%b, need 8080808080808080", frame1, !ok);
        end
        for (int k = 0; k < 7; k++) wait_upd(1, ok);
        vectors++;
        if (!ok || frame1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL glyph_b: frame=%h timeout=%b, need all ones", frame1, !ok);
        end
    endtask

    task automatic test_enable_freeze();
        bit ok;
        int gap;
        do_clear();
        enable = 1'b1;
        push_one(64'h0000_0000_0000_F00F);
        for (int k = 0; k < 3; k++) wait_upd(0, ok);
        vectors++;
        if (!ok || frame0 !== 64'h0000_0000_0000_00E0) begin
            errors++;
            $display("FAIL col3: frame=%h timeout=%b, need e0", frame0, !ok);
        end
        @(negedge clk);
        enable = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (upd0 !== 1'b0 || frame0 !== 64'h0000_0000_0000_00E0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL frozen: frame=%h upd=%b, need e0 and 0", frame0, upd0);
        end
        enable = 1'b1;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            gap++;
            if (upd0) break;
        end
        vectors++;
        if (gap !== 3 || frame0 !== 64'h0000_0000_0000_00F0) begin
            errors++;
            $display("FAIL resume: cycles=%0d frame=%h, need 3 and f0", gap, frame0);
        end
        wait_upd(0, ok);
        vectors++;
        if (!ok || frame0 !== 64'h0000_0000_0000_8078) begin
            errors++;
            $display("FAIL col5: frame=%h timeout=%b, need 8078", frame0, !ok);
        end
    endtask

    task automatic test_clear();
        bit ok;
        do_clear();
        enable = 1'b1;
        @(negedge clk);
        glyph_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        glyph_valid = 1'b1;
        @(negedge clk);
        glyph_in    = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        glyph_in    = 64'h0F0F_0F0F_0F0F_0F0F;
        @(negedge clk);
        glyph_valid = 1'b0;
        for (int k = 0; k < 5; k++) wait_upd(0, ok);
        vectors++;
        if (!ok || frame0 !== 64'hF8F8_F8F8_F8F8_F8F8 || count0 !== 4'd2) begin
            errors++;
            $display("FAIL pre_clear: frame=%h count=%0d timeout=%b, need f8f8f8f8f8f8f8f8 and 2", frame0, count0, !ok);
        end
        clear       = 1'b1;
        glyph_in    = 64'hAAAA_AAAA_AAAA_AAAA;
        glyph_valid = 1'b1;
        #1;
        vectors++;
        if (ready0 !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: ready=%b, need 0", ready0);
        end
        @(negedge clk);
        clear       = 1'b0;
        glyph_valid = 1'b0;
        vectors++;
        if (frame0 !== 64'd0 || count0 !== 4'd0 || busy0 !== 1'b0 || upd0 !== 1'b1) begin
            errors++;
            $display("FAIL clear: frame=%h count=%0d busy=%b upd=%b, need 0 0 0 1", frame0, count0, busy0, upd0);
        end
        @(negedge clk);
        vectors++;
        if (upd0 !== 1'b0 || count0 !== 4'd0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: upd=%b count=%0d busy=%b, need 0 0 0", upd0, count0, busy0);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_clear();
        enable = 1'b1;
        push_one(64'hFFFF_FFFF_FFFF_FFFF);
        push_one(64'h5555_5555_5555_5555);
        for (int k = 0; k < 3; k++) wait_upd(0, ok);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (frame0 !== 64'd0 || busy0 !== 1'b0 || count0 !== 4'd0 || ready0 !== 1'b0 || upd0 !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: frame=%h busy=%b count=%0d ready=%b upd=%b, need all 0",
                     frame0, busy0, count0, ready0, upd0);
        end
        @(negedge clk);
        rst = 1'b1;
        push_one(64'h0000_0000_0000_00FF);
        wait_upd(0, ok);
        vectors++;
        if (!ok || frame0 !== 64'h80) begin
            errors++;
            $display("FAIL post_rst: frame=%h timeout=%b, need 80", frame0, !ok);
        end
    endtask

    initial begin
        test_reset();
        test_scroll_gap();
        test_fifo_full();
        test_back_to_back();
        test_enable_freeze();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
